// File: rtl/song_sequencer.sv
// song_sequencer: top-level playback controller for the music player.
// Walks the song ROM one word at a time and hands each note/duration pair
// to the note player over the new_note/note_done handshake. It also owns the
// play/pause state, song selection and end-of-song detection.
module song_sequencer #(
    parameter int SONG_BITS = 2,
    parameter int NOTE_BITS = 5
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           play_pause,
    input  logic                           next_song,
    output logic [SONG_BITS+NOTE_BITS-1:0] rom_addr,
    input  logic [11:0]                    rom_data,
    output logic [5:0]                     note,
    output logic [5:0]                     duration,
    output logic                           new_note,
    input  logic                           note_done,
    output logic                           play,
    output logic                           reset_play,
    output logic [SONG_BITS-1:0]           song,
    output logic                           song_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_ISSUE,
        S_WAIT_DONE,
        S_END
    } state_t;

    state_t               state;
    logic [NOTE_BITS-1:0] note_idx;
    // High only in the first cycle after reset releases; user pulses are
    // ignored while the note player is still being held in reset.
    logic                 post_reset;

    logic [5:0]           word_note;
    logic [5:0]           word_dur;
    logic                 end_marker;
    logic                 last_word;

    // The ROM address is a plain concatenation of two registers, so it is
    // glitch-free and valid for the whole FETCH cycle.
    assign rom_addr   = {song, note_idx};

    assign word_note  = rom_data[11:6];
    assign word_dur   = rom_data[5:0];
    assign end_marker = (word_dur == 6'd0);
    assign last_word  = (note_idx == {NOTE_BITS{1'b1}});

    // Playback FSM: all outputs are registered and change on the rising edge,
    // except the asynchronous reset values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            song       <= '0;
            note_idx   <= '0;
            play       <= 1'b0;
            new_note   <= 1'b0;
            song_done  <= 1'b0;
            note       <= '0;
            duration   <= '0;
            reset_play <= 1'b1;
            post_reset <= 1'b1;
        end else begin
            // Single-cycle pulses default low.
            new_note   <= 1'b0;
            song_done  <= 1'b0;
            reset_play <= 1'b0;
            post_reset <= 1'b0;

            if (post_reset) begin
                // Note player still in reset: hold everything.
                state <= S_IDLE;
            end else if (next_song) begin
                // Song change wins over everything; the play state is kept.
                song       <= song + SONG_BITS'(1);
                note_idx   <= '0;
                reset_play <= 1'b1;
                state      <= play ? S_FETCH : S_IDLE;
            end else if (play_pause) begin
                if (state == S_IDLE) begin
                    // Resume from the held note index.
                    play  <= 1'b1;
                    state <= S_FETCH;
                end else begin
                    // Pause: note_idx is held so the note restarts on resume.
                    play  <= 1'b0;
                    state <= S_IDLE;
                    if (state == S_END) begin
                        note_idx <= '0;
                    end
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        state <= S_IDLE;
                    end
                    S_FETCH: begin
                        state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (end_marker) begin
                            song_done  <= 1'b1;
                            reset_play <= 1'b1;
                            state      <= S_END;
                        end else begin
                            note     <= word_note;
                            duration <= word_dur;
                            new_note <= 1'b1;
                            state    <= S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        state <= S_WAIT_DONE;
                    end
                    S_WAIT_DONE: begin
                        if (note_done) begin
                            if (last_word) begin
                                song_done  <= 1'b1;
                                reset_play <= 1'b1;
                                state      <= S_END;
                            end else begin
                                note_idx <= note_idx + NOTE_BITS'(1);
                                state    <= S_FETCH;
                            end
                        end
                    end
                    S_END: begin
                        play     <= 1'b0;
                        note_idx <= '0;
                        state    <= S_IDLE;
                    end
                    default: begin
                        play  <= 1'b0;
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/song_sequencer.md
# song_sequencer

Top-level playback controller for the music player. Walks the song ROM note by note and hands each note/duration pair to the note player over the new_note/note_done handshake. Owns the play state, pause/resume, song selection and end-of-song detection. Drives the note player's play_enable and reset inputs.

## Interface

- SONG_BITS, 2: width of the song index (4 songs).
- NOTE_BITS, 5: width of the note index within a song (32 ROM words per song).

- clk  in  1  system clock (sys_clk).
- reset  in  1  asynchronous, active-low reset.
- play_pause  in  1  one-cycle pulse, debounced upstream; toggles play/pause.
- next_song  in  1  one-cycle pulse; selects the next song.
- rom_addr  out  SONG_BITS+NOTE_BITS  song ROM address, {song, note_idx}; registered.
- rom_data  in  12  song ROM word, {note[11:6], duration[5:0]}; synchronous ROM, 1-cycle read latency.
- note  out  6  note code to the note player; registered.
- duration  out  6  duration to the note player; registered.
- new_note  out  1  one-cycle pulse; note and duration are valid.
- note_done  in  1  one-cycle pulse from the note player; the current note has finished.
- play  out  1  play_enable to the note player.
- reset_play  out  1  one-cycle reset pulse to the note player.
- song  out  SONG_BITS  current song index.
- song_done  out  1  one-cycle pulse at end of song.

## Operation

- States: IDLE, FETCH, WAIT, ISSUE, WAIT_DONE, END.
- Reset values while reset=0:
  - state=IDLE, song=0, note_idx=0.
  - play=0, new_note=0, song_done=0, note=0, duration=0.
  - reset_play=1 (asynchronously set). It clears on the first clock edge after reset releases.
- IDLE (play=0):
  - play_pause → FETCH and set play=1.
  - note_idx is kept, so resume restarts the interrupted note from its beginning.
- FETCH: rom_addr={song, note_idx} is driven. Next state is WAIT.
- WAIT: the ROM word is sampled at the end of this cycle.
  - If rom_data[5:0]==0 (end marker) → END.
  - Otherwise, register note/duration from the word → ISSUE.
- ISSUE: new_note=1 for exactly this cycle. Next state is WAIT_DONE.
- WAIT_DONE: on note_done:
  - If note_idx == all-ones (last word) → END.
  - Otherwise, note_idx+1 → FETCH.
- END:
  - song_done=1 and reset_play=1 for this cycle.
  - note_idx=0, play=0, then → IDLE. Playback stops; the song is unchanged.
- Note code 0 is a rest. It is passed through unchanged and sequenced like any other note.
- play_pause in any state other than IDLE:
  - Pause: play=0 → IDLE next cycle. note_idx is held.
  - No reset_play pulse.
- next_song in any state:
  - song ← song+1, wrapping modulo 2^SONG_BITS. note_idx ← 0.
  - reset_play pulses for 1 cycle and any pending note is abandoned.
  - If play=1 → FETCH; otherwise → IDLE.
- Simultaneous events, in priority order: next_song > play_pause > note_done.
  - next_song together with play_pause: the song is changed and the play state is unchanged.
  - play_pause together with note_done: pause wins and note_idx does not advance.
- note_done is ignored outside WAIT_DONE.
- play_pause and next_song are ignored during reset_play=1 after reset.

## Timing

- play_pause pulse in cycle t from IDLE:
  - play=1 from t+1.
  - FETCH in t+1, WAIT in t+2.
  - new_note=1 in t+3, with note/duration already valid in t+3.
- note_done in cycle t, not the last word: FETCH in t+1, next new_note in t+3. The gap between notes is 3 cycles.
- note_done in cycle t on the last word: song_done=reset_play=1 in t+1, play=0 from t+2.
- End marker read for the word fetched in cycle t: song_done in t+2.
- next_song in cycle t:
  - song and reset_play update in t+1.
  - If playing, the first new_note of the new song comes in t+3.
- Every registered output changes only on the rising edge of clk. The exceptions are reset_play (asynchronously set) and the outputs asynchronously cleared by reset.
- note and duration hold their value until the next ISSUE.

## Test plan

- Reset then play: ROM song 0 = {(12,4),(20,8),(0 marker)}; pulse play_pause → new_note at t+3 with note=12, duration=4 and rom_addr=0. After note_done → note=20, duration=8 at rom_addr=1. After the next note_done → song_done pulse, play=0, note_idx=0.
- Full song without a marker: all 32 words non-zero; answer each new_note with note_done → 32 new_note pulses with rom_addr 0..31, then song_done. rom_addr never wraps into the next song.
- Pause/resume: pause while in WAIT_DONE on note_idx=5 → play=0 next cycle. A stray note_done is ignored. Resume → rom_addr=5 and the same note is reissued.
- next_song while playing song 3 mid-note → song=0 and reset_play pulse in t+1. First new_note comes from rom_addr {0,0} in t+3.
- Simultaneous events:
  - play_pause with note_done in WAIT_DONE → paused, note_idx unchanged.
  - next_song with play_pause in IDLE → song+1, still paused, no new_note.
- Async reset asserted mid-note → play=0 and reset_play=1 immediately, without waiting for a clock edge. After release: song=0, IDLE, and reset_play clears on the first edge.
